mult_stim_gen: RTL and testbench

Synthesizable, parametrised stimulus generator and self-checker for the signed parity-protected multiplier. It is the on-chip successor to the bench-only pattern generator, and adds:
- configurable operand width and transaction count
- selectable generation modes
- parity-error injection
- expected-result checking, error counting and a handshake timeout

It sits beside the multiplier and drives its req/ack/result_rdy interface directly.

---
 rtl/mult_stim_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_mult_stim_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_stim_gen.sv
// On-chip stimulus generator and self-checker for the signed parity-protected
// multiplier. Drives operands over a req/ack handshake, waits for result_rdy,
// compares the returned product against a locally computed expectation and
// keeps transaction and error counts.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | after reset, waiting for start
// S_GEN      | advance LFSR, register operands, parities and injection type
// S_REQ      | req high, waiting for ack (bounded by wait timer)
// S_WAIT_RDY | waiting for result_rdy (bounded by wait timer)
// S_CHECK    | compare captured result, count transaction
// S_DONE     | run finished or aborted; done level held until next start
module mult_stim_gen #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_TXN   = 1000,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2345,
    parameter bit          PERR_EN   = 1'b1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic [DATA_W-1:0]     arg_a,
    output logic                  arg_a_parity,
    output logic [DATA_W-1:0]     arg_b,
    output logic                  arg_b_parity,
    output logic                  req,
    input  logic                  ack,
    input  logic                  result_rdy,
    input  logic [2*DATA_W-1:0]   result,
    input  logic                  result_parity,
    input  logic                  arg_parity_error,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [31:0]           txn_cnt,
    output logic [15:0]           err_cnt
);

    localparam int unsigned RES_W  = 2 * DATA_W;
    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1, right-shifting form
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Down-counter load: terminal count at zero gives exactly TIMEOUT cycles
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_REQ,
        S_WAIT_RDY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [31:0]         lfsr;
    logic [31:0]         lfsr_step;
    logic [1:0]          mode_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_tc;
    logic                inj_a_q, inj_b_q;
    logic [RES_W-1:0]    res_q;
    logic                res_par_q;
    logic                ape_q;

    logic [DATA_W-1:0]   rand_a, rand_b;
    logic [DATA_W-1:0]   corn_a, corn_b;
    logic [DATA_W-1:0]   a_nxt, b_nxt;
    logic                inj_en, inj_a_nxt, inj_b_nxt;

    logic [RES_W-1:0]    a_ext, b_ext, prod;
    logic                inj_any;
    logic [RES_W-1:0]    exp_res;
    logic                exp_par;
    logic                mismatch;
    logic [31:0]         txn_inc;
    logic                last_txn;
    logic [15:0]         err_sat_inc;

    function automatic logic [DATA_W-1:0] corner_val(input logic [2:0] idx);
        logic [DATA_W-1:0] v;
        case (idx)
            3'd0:         v = '0;
            3'd1:         v = DATA_W'(1);
            3'd2, 3'd5:   v = {1'b0, {(DATA_W-1){1'b1}}};
            3'd3, 3'd6:   v = '1;
            default:      v = {1'b1, {(DATA_W-1){1'b0}}};
        endcase
        return v;
    endfunction

    // Next LFSR value and operand candidates derived from it
    always_comb begin
        lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
        rand_a    = lfsr_step[DATA_W-1:0];
        rand_b    = lfsr_step[31 -: DATA_W];
        corn_a    = corner_val(lfsr_step[2:0]);
        corn_b    = corner_val(lfsr_step[10:8]);
        a_nxt     = rand_a;
        b_nxt     = rand_b;
        case (mode_q)
            2'b01: begin
                a_nxt = corn_a;
                b_nxt = corn_b;
            end
            2'b10: begin
                a_nxt = (lfsr_step[2:0]  < 3'd5) ? corn_a : rand_a;
                b_nxt = (lfsr_step[10:8] < 3'd5) ? corn_b : rand_b;
            end
            2'b11: begin
                a_nxt = txn_cnt[DATA_W-1:0];
                b_nxt = ~txn_cnt[DATA_W-1:0];
            end
            default: ;
        endcase
        // L[5:4]: 01 both, 10 B only, 11 A only
        inj_en    = PERR_EN && (mode_q != 2'b11);
        inj_a_nxt = inj_en && lfsr_step[4];
        inj_b_nxt = inj_en && (lfsr_step[5] ^ lfsr_step[4]);
    end

    // Expected multiplier response for the operands currently on the bus
    always_comb begin
        a_ext       = {{DATA_W{arg_a[DATA_W-1]}}, arg_a};
        b_ext       = {{DATA_W{arg_b[DATA_W-1]}}, arg_b};
        prod        = a_ext * b_ext;
        inj_any     = inj_a_q | inj_b_q;
        exp_res     = inj_any ? '0 : prod;
        exp_par     = inj_any ? 1'b0 : ^prod;
        mismatch    = (res_q != exp_res) || (res_par_q != exp_par) || (ape_q != inj_any);
        txn_inc     = txn_cnt + 32'd1;
        last_txn    = (txn_inc == NUM_TXN);
        err_sat_inc = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
        wait_tc     = (wait_cnt == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_GEN;
            end
            S_GEN: begin
                busy      = 1'b1;
                state_nxt = S_REQ;
            end
            S_REQ: begin
                busy = 1'b1;
                req  = 1'b1;
                if (ack)          state_nxt = S_WAIT_RDY;
                else if (wait_tc) state_nxt = S_DONE;
            end
            S_WAIT_RDY: begin
                busy = 1'b1;
                if (result_rdy)   state_nxt = S_CHECK;
                else if (wait_tc) state_nxt = S_DONE;
            end
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = last_txn ? S_DONE : S_GEN;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_GEN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: LFSR, operands, wait timer, result capture and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr         <= LFSR_SEED;
            mode_q       <= 2'b00;
            arg_a        <= '0;
            arg_b        <= '0;
            arg_a_parity <= 1'b0;
            arg_b_parity <= 1'b0;
            inj_a_q      <= 1'b0;
            inj_b_q      <= 1'b0;
            wait_cnt     <= '0;
            res_q        <= '0;
            res_par_q    <= 1'b0;
            ape_q        <= 1'b0;
            txn_cnt      <= 32'd0;
            err_cnt      <= 16'd0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        txn_cnt <= 32'd0;
                        err_cnt <= 16'd0;
                        timeout <= 1'b0;
                        mode_q  <= mode;
                    end
                end
                S_GEN: begin
                    lfsr         <= lfsr_step;
                    arg_a        <= a_nxt;
                    arg_b        <= b_nxt;
                    arg_a_parity <= (^a_nxt) ^ inj_a_nxt;
                    arg_b_parity <= (^b_nxt) ^ inj_b_nxt;
                    inj_a_q      <= inj_a_nxt;
                    inj_b_q      <= inj_b_nxt;
                    wait_cnt     <= WAIT_LOAD;
                end
                S_REQ: begin
                    if (ack) begin
                        wait_cnt <= WAIT_LOAD;
                    end else if (wait_tc) begin
                        timeout <= 1'b1;
                        err_cnt <= err_sat_inc;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (result_rdy) begin
                        res_q     <= result;
                        res_par_q <= result_parity;
                        ape_q     <= arg_parity_error;
                    end else if (wait_tc) begin
                        timeout <= 1'b1;
                        err_cnt <= err_sat_inc;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    txn_cnt <= txn_inc;
                    if (mismatch) err_cnt <= err_sat_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_stim_gen.sv
// Bench for mult_stim_gen: a multiplier responder plus an independent
// reference model of operand generation and error accounting.
module tb_mult_stim_gen;

    localparam logic [31:0] SEED = 32'hACE1_2345;

    logic        clk, rst_n;
    logic        start, ack, result_rdy, result_parity, ape;
    logic [1:0]  mode;
    logic [15:0] arg_a, arg_b;
    logic        arg_a_parity, arg_b_parity, req, busy, done, timeout;
    logic [31:0] result, txn_cnt;
    logic [15:0] err_cnt;

    logic        s_start, s_ack, s_rdy, s_rpar, s_ape;
    logic [1:0]  s_mode;
    logic [15:0] s_arg_a, s_arg_b;
    logic        s_apar, s_bpar, s_req, s_busy, s_done, s_timeout;
    logic [31:0] s_result, s_txn_cnt;
    logic [15:0] s_err_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_lfsr;
    int          m_err;
    int          lat_max;

    mult_stim_gen #(.DATA_W(16), .NUM_TXN(1000), .LFSR_SEED(SEED), .PERR_EN(1'b1), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .arg_a(arg_a), .arg_a_parity(arg_a_parity), .arg_b(arg_b), .arg_b_parity(arg_b_parity),
        .req(req), .ack(ack), .result_rdy(result_rdy), .result(result),
        .result_parity(result_parity), .arg_parity_error(ape),
        .busy(busy), .done(done), .timeout(timeout), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
    );

    mult_stim_gen #(.DATA_W(16), .NUM_TXN(4), .LFSR_SEED(SEED), .PERR_EN(1'b0), .TIMEOUT(255)) dut_sw (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode),
        .arg_a(s_arg_a), .arg_a_parity(s_apar), .arg_b(s_arg_b), .arg_b_parity(s_bpar),
        .req(s_req), .ack(s_ack), .result_rdy(s_rdy), .result(s_result),
        .result_parity(s_rpar), .arg_parity_error(s_ape),
        .busy(s_busy), .done(s_done), .timeout(s_timeout), .txn_cnt(s_txn_cnt), .err_cnt(s_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One step of polynomial division by x^32 + x^22 + x^2 + x + 1
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        logic [31:0] poly;
        logic        fb;
        poly = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
        fb   = l[0];
        l    = l >> 1;
        if (fb) l = l ^ poly;
        return l;
    endfunction

    function automatic logic [15:0] corner16(input logic [2:0] i);
        case (i)
            3'd0: return 16'h0000;
            3'd1: return 16'h0001;
            3'd2: return 16'h7FFF;
            3'd3: return 16'hFFFF;
            3'd4: return 16'h8000;
            3'd5: return 16'h7FFF;
            3'd6: return 16'hFFFF;
            default: return 16'h8000;
        endcase
    endfunction

    function automatic bit is_corner(input logic [15:0] v);
        return (v == 16'h0000) || (v == 16'h0001) || (v == 16'h7FFF) ||
               (v == 16'hFFFF) || (v == 16'h8000);
    endfunction

    task automatic predict(input logic [1:0] m, input int idx, input logic [31:0] l,
                           output logic [15:0] a, output logic [15:0] b,
                           output bit ia, output bit ib);
        int inj;
        int ca, cb;
        ca = int'(l[2:0]);
        cb = int'(l[10:8]);
        case (m)
            2'd0: begin a = l[15:0]; b = l[31:16]; end
            2'd1: begin a = corner16(l[2:0]); b = corner16(l[10:8]); end
            2'd2: begin
                a = (ca < 5) ? corner16(l[2:0])  : l[15:0];
                b = (cb < 5) ? corner16(l[10:8]) : l[31:16];
            end
            default: begin a = 16'(idx); b = ~16'(idx); end
        endcase
        inj = (m == 2'd3) ? 0 : int'(l[5:4]);
        ia  = (inj == 1) || (inj == 3);
        ib  = (inj == 1) || (inj == 2);
    endtask

    // One handshake on the main instance; responder plays the multiplier
    task automatic do_txn(input logic [1:0] m, input int idx, input bit f_zero,
                          input bit f_ape, input bit abort, output bit ok);
        logic [15:0] ea, eb;
        bit          ia, ib, bad;
        int          t;
        int          pa;
        logic [31:0] rsp, exp_r;
        logic        rsp_p, rsp_e, exp_p, exp_e;
        ok = 1'b0;
        t  = 0;
        while (!req && t < 50) begin @(negedge clk); t++; end
        if (!req) begin check("req_rise", 64'(req), 64'd1); return; end
        m_lfsr = lfsr_next(m_lfsr);
        predict(m, idx, m_lfsr, ea, eb, ia, ib);
        check("arg_a", 64'(arg_a), 64'(ea));
        check("arg_b", 64'(arg_b), 64'(eb));
        check("par_a", 64'(arg_a_parity), 64'((^ea) ^ ia));
        check("par_b", 64'(arg_b_parity), 64'((^eb) ^ ib));
        if (m == 2'd1) check("corner_set", 64'(is_corner(arg_a) && is_corner(arg_b)), 64'd1);
        repeat ($urandom_range(0, lat_max)) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("req_drop", 64'(req), 64'd0);
        if (abort) begin ok = 1'b1; return; end
        repeat ($urandom_range(0, lat_max)) @(negedge clk);
        bad = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
        pa  = int'($signed(arg_a)) * int'($signed(arg_b));
        if (bad) begin
            rsp = 32'd0; rsp_p = 1'b0; rsp_e = !f_ape;
        end else if (f_zero && arg_a == 16'h7FFF && arg_b == 16'h7FFF) begin
            rsp = 32'd0; rsp_p = 1'b0; rsp_e = 1'b0;
        end else begin
            rsp = 32'(pa); rsp_p = ^rsp; rsp_e = 1'b0;
        end
        if (ia || ib) begin
            exp_r = 32'd0; exp_p = 1'b0; exp_e = 1'b1;
        end else begin
            exp_r = 32'(int'($signed(ea)) * int'($signed(eb)));
            exp_p = ^exp_r; exp_e = 1'b0;
        end
        if (rsp != exp_r || rsp_p != exp_p || rsp_e != exp_e) m_err++;
        result = rsp; result_parity = rsp_p; ape = rsp_e; result_rdy = 1'b1;
        @(negedge clk);
        result_rdy = 1'b0;
        result = $urandom;
        ok = 1'b1;
    endtask

    task automatic do_run(input logic [1:0] m, input bit f_zero, input bit f_ape);
        bit ok;
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        m_err = 0;
        check("busy_start", 64'(busy), 64'd1);
        for (int i = 0; i < 1000; i++) begin
            do_txn(m, i, f_zero, f_ape, 1'b0, ok);
            if (!ok) break;
        end
        @(negedge clk);
        check("run_done", 64'(done), 64'd1);
        check("run_busy", 64'(busy), 64'd0);
        check("run_txn", 64'(txn_cnt), 64'd1000);
        check("run_err", 64'(err_cnt), 64'(m_err));
        check("run_tmo", 64'(timeout), 64'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } sw_vec_t;

    sw_vec_t sw_tbl [4];

    initial begin
        bit ok;
        int cnt;
        sw_tbl[0] = '{16'h0000, 16'hFFFF, 32'h0000_0000};
        sw_tbl[1] = '{16'h0001, 16'hFFFE, 32'hFFFF_FFFE};
        sw_tbl[2] = '{16'h0002, 16'hFFFD, 32'hFFFF_FFFA};
        sw_tbl[3] = '{16'h0003, 16'hFFFC, 32'hFFFF_FFF4};

        rst_n = 1'b0; start = 1'b0; mode = 2'b00; ack = 1'b0; result_rdy = 1'b0;
        result = '0; result_parity = 1'b0; ape = 1'b0;
        s_start = 1'b0; s_mode = 2'b00; s_ack = 1'b0; s_rdy = 1'b0;
        s_result = '0; s_rpar = 1'b0; s_ape = 1'b0;
        m_lfsr = SEED; m_err = 0; lat_max = 1;
        repeat (3) @(negedge clk);
        check("rst_outs", {arg_a, arg_b, arg_a_parity, arg_b_parity, req, busy, done, timeout},
              64'd0);
        check("rst_cnts", {txn_cnt, err_cnt}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", {req, busy, done, timeout}, 64'd0);

        // Sweep instance: table of expected operands and products
        s_mode = 2'b11; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            while (!s_req && cnt < 50) begin @(negedge clk); cnt++; end
            check("sw_req", 64'(s_req), 64'd1);
            check("sw_arg_a", 64'(s_arg_a), 64'(sw_tbl[i].a));
            check("sw_arg_b", 64'(s_arg_b), 64'(sw_tbl[i].b));
            check("sw_par", {s_apar, s_bpar}, {^sw_tbl[i].a, ^sw_tbl[i].b});
            s_ack = 1'b1;
            if (i == 2) begin s_rdy = 1'b1; s_result = 32'hDEAD_BEEF; s_rpar = 1'b1; end
            @(negedge clk);
            s_ack = 1'b0; s_rdy = 1'b0;
            @(negedge clk);
            s_result = sw_tbl[i].p; s_rpar = ^sw_tbl[i].p; s_ape = 1'b0; s_rdy = 1'b1;
            @(negedge clk);
            s_rdy = 1'b0;
        end
        @(negedge clk);
        check("sw_done", 64'(s_done), 64'd1);
        check("sw_txn", 64'(s_txn_cnt), 64'd4);
        check("sw_err", 64'(s_err_cnt), 64'd0);

        // Main instance: corner run with near-ideal latency
        lat_max = 1;
        do_run(2'b01, 1'b0, 1'b0);
        // Mixed run with random latencies
        lat_max = 3;
        do_run(2'b10, 1'b0, 1'b0);

        // Timeout: never ack
        mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!req && cnt < 50) begin @(negedge clk); cnt++; end
        m_lfsr = lfsr_next(m_lfsr);
        cnt = 0;
        while (req && cnt < 400) begin cnt++; @(negedge clk); end
        check("tmo_req_cycles", 64'(cnt), 64'd255);
        check("tmo_flags", {req, timeout, done, busy}, {1'b0, 1'b1, 1'b1, 1'b0});
        check("tmo_err", 64'(err_cnt), 64'd1);
        check("tmo_txn", 64'(txn_cnt), 64'd0);

        // Faulty multiplier: zero product on 7FFF*7FFF, no ape on bad parity
        lat_max = 2;
        do_run(2'b01, 1'b1, 1'b1);

        // Asynchronous reset while waiting for result_rdy
        mode = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) do_txn(2'b01, i, 1'b0, 1'b0, (i == 3), ok);
        check("pre_rst_txn", 64'(txn_cnt), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", {req, busy, done}, 64'd0);
        check("arst_txn", 64'(txn_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = SEED;
        @(negedge clk);
        do_run(2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
